// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle control FSM and the MIPS datapath.
// master = control unit (drives the select lines), slave = datapath.
interface multicycle_control_unit_if #(
    parameter int STATE_W = 3
);
    logic [5:0]         opcode;
    logic               zero;
    logic               sign;
    logic [STATE_W-1:0] State;
    logic               PCWre;
    logic               IRWre;
    logic               InsMemRW;
    logic               RegWre;
    logic [1:0]         RegDst;
    logic               WrRegDSrc;
    logic               ALUSrcA;
    logic               ALUSrcB;
    logic               ExtSel;
    logic [2:0]         ALUOp;
    logic               mRD;
    logic               mWR;
    logic               DBDataSrc;
    logic [1:0]         PCSrc;

    modport master (
        input  opcode, zero, sign,
        output State, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
               ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR, DBDataSrc, PCSrc
    );

    modport slave (
        output opcode, zero, sign,
        input  State, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
               ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR, DBDataSrc, PCSrc
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: IF/ID/EXE/MEM/WB sequencing, 2-5 cycles per instruction.
// Controls are combinational from state/opcode/flags and are all forced low while Reset is low.
module multicycle_control_unit #(
    parameter logic [5:0] HALT_OP = 6'b111111,
    parameter int         STATE_W = 3
) (
    input logic                       CLK,
    input logic                       Reset,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        S_IF   = STATE_W'(0),
        S_ID   = STATE_W'(1),
        S_EXE  = STATE_W'(2),
        S_MEM  = STATE_W'(3),
        S_WB   = STATE_W'(4),
        S_HALT = STATE_W'(7)
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI  = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000, OP_AND  = 6'b010001, OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000, OP_SLT  = 6'b100110, OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000, OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100, OP_BNE  = 6'b110101, OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000, OP_JR   = 6'b111001, OP_JAL   = 6'b111010;

    state_t     state;
    logic       is_rtype, is_itype, is_branch, is_jump, is_defined;
    logic       src_a, src_b, ext_sel, taken, is_mem;
    logic [2:0] alu_op;

    always_comb begin
        is_rtype   = 1'b0;
        is_itype   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_defined = 1'b1;
        alu_op     = 3'b000;
        src_a      = 1'b0;
        src_b      = 1'b0;
        case (bus.opcode)
            OP_ADD:   is_rtype = 1'b1;
            OP_SUB:   begin is_rtype = 1'b1; alu_op = 3'b001; end
            OP_ADDI:  begin is_itype = 1'b1; src_b = 1'b1; end
            OP_OR:    begin is_rtype = 1'b1; alu_op = 3'b011; end
            OP_AND:   begin is_rtype = 1'b1; alu_op = 3'b100; end
            OP_ORI:   begin is_itype = 1'b1; src_b = 1'b1; alu_op = 3'b011; end
            OP_SLL:   begin is_rtype = 1'b1; src_a = 1'b1; alu_op = 3'b010; end
            OP_SLT:   begin is_rtype = 1'b1; alu_op = 3'b101; end
            OP_SLTIU: begin is_itype = 1'b1; src_b = 1'b1; alu_op = 3'b110; end
            OP_SW:    src_b = 1'b1;
            OP_LW:    begin is_itype = 1'b1; src_b = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLTZ: begin is_branch = 1'b1; alu_op = 3'b001; end
            OP_J, OP_JR, OP_JAL:     is_jump = 1'b1;
            default:  is_defined = 1'b0;
        endcase
        ext_sel = (bus.opcode != OP_ORI);
        is_mem  = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
        taken   = ((bus.opcode == OP_BEQ)  &&  bus.zero) ||
                  ((bus.opcode == OP_BNE)  && !bus.zero) ||
                  ((bus.opcode == OP_BLTZ) &&  bus.sign);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IF;
        end else begin
            case (state)
                S_IF:  state <= S_ID;
                S_ID: begin
                    if (bus.opcode == HALT_OP)       state <= S_HALT;
                    else if (is_jump || !is_defined) state <= S_IF;
                    else                             state <= S_EXE;
                end
                S_EXE: begin
                    if (is_branch)   state <= S_IF;
                    else if (is_mem) state <= S_MEM;
                    else             state <= S_WB;
                end
                S_MEM:   state <= (bus.opcode == OP_LW) ? S_WB : S_IF;
                S_WB:    state <= S_IF;
                S_HALT:  state <= S_HALT;
                default: state <= S_IF;
            endcase
        end
    end

    always_comb begin
        bus.State     = state;
        bus.PCWre     = 1'b0;
        bus.IRWre     = 1'b0;
        bus.InsMemRW  = 1'b0;
        bus.RegWre    = 1'b0;
        bus.RegDst    = 2'b00;
        bus.WrRegDSrc = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 1'b0;
        bus.ExtSel    = 1'b0;
        bus.ALUOp     = 3'b000;
        bus.mRD       = 1'b0;
        bus.mWR       = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.PCSrc     = 2'b00;
        if (Reset) begin
            // ALU controls stay decoded through MEM and WB so the datapath result holds.
            if (state == S_EXE || state == S_MEM || state == S_WB) begin
                bus.ALUOp   = alu_op;
                bus.ALUSrcA = src_a;
                bus.ALUSrcB = src_b;
                bus.ExtSel  = ext_sel;
            end
            case (state)
                S_IF: begin
                    bus.IRWre    = 1'b1;
                    bus.InsMemRW = 1'b1;
                end
                S_ID: begin
                    if (bus.opcode == OP_J || bus.opcode == OP_JAL) begin
                        bus.PCWre = 1'b1;
                        bus.PCSrc = 2'b11;
                        bus.RegWre = (bus.opcode == OP_JAL);
                    end else if (bus.opcode == OP_JR) begin
                        bus.PCWre = 1'b1;
                        bus.PCSrc = 2'b10;
                    end else if (!is_defined && bus.opcode != HALT_OP) begin
                        bus.PCWre = 1'b1;
                    end
                end
                S_EXE: begin
                    if (is_branch) begin
                        bus.PCWre = 1'b1;
                        bus.PCSrc = taken ? 2'b01 : 2'b00;
                    end
                end
                S_MEM: begin
                    bus.mRD   = (bus.opcode == OP_LW);
                    bus.mWR   = (bus.opcode == OP_SW);
                    bus.PCWre = (bus.opcode == OP_SW);
                end
                S_WB: begin
                    bus.RegWre    = 1'b1;
                    bus.WrRegDSrc = 1'b1;
                    bus.PCWre     = 1'b1;
                    bus.DBDataSrc = (bus.opcode == OP_LW);
                    bus.RegDst    = is_rtype ? 2'b10 : (is_itype ? 2'b01 : 2'b00);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed and random instruction streams vs a phase-list reference model.
module tb_multicycle_control_unit;
    localparam logic [5:0] HALT_OP = 6'b111111;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
    localparam logic [5:0] OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
    localparam logic [5:0] SLL = 6'b011000, SLT = 6'b100110, SLTIU = 6'b100111;
    localparam logic [5:0] SW = 6'b110000, LW = 6'b110001;
    localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
    localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010;
    localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4, P_HALT = 7;

    logic CLK = 1'b0;
    logic Reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    multicycle_control_unit_if #(.STATE_W(3)) bus();
    multicycle_control_unit #(.HALT_OP(HALT_OP), .STATE_W(3)) dut (
        .CLK(CLK), .Reset(Reset), .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] observed();
        return {bus.State, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre, bus.RegDst,
                bus.WrRegDSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.ALUOp,
                bus.mRD, bus.mWR, bus.DBDataSrc, bus.PCSrc};
    endfunction

    function automatic bit is_defined(input logic [5:0] op);
        return op inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTIU, SW, LW,
                          BEQ, BNE, BLTZ, J, JR, JAL};
    endfunction

    // Expected control word for one cycle, straight from the per-phase output table.
    function automatic logic [20:0] model(input int ph, input logic [5:0] op, input logic z, input logic s);
        logic [2:0] st, aop;
        logic [1:0] rd, pcs;
        logic pcw, irw, imr, rw, wds, asa, asb, ext, mrd, mwr, dbs;
        bit rtype, itype, taken;
        {st, aop, rd, pcs, pcw, irw, imr, rw, wds, asa, asb, ext, mrd, mwr, dbs} = '0;
        rtype = op inside {ADD, SUB, OR_, AND_, SLL, SLT};
        itype = op inside {ADDI, ORI, SLTIU, LW};
        taken = (op == BEQ && z) || (op == BNE && !z) || (op == BLTZ && s);
        if (ph == P_EXE || ph == P_MEM || ph == P_WB) begin
            case (op)
                SUB, BEQ, BNE, BLTZ: aop = 3'd1;
                SLL:                 aop = 3'd2;
                OR_, ORI:            aop = 3'd3;
                AND_:                aop = 3'd4;
                SLT:                 aop = 3'd5;
                SLTIU:               aop = 3'd6;
                default:             aop = 3'd0;
            endcase
            asa = (op == SLL);
            asb = op inside {ADDI, ORI, SLTIU, LW, SW};
            ext = (op != ORI);
        end
        case (ph)
            P_IF: begin st = 3'b000; irw = 1; imr = 1; end
            P_ID: begin
                st = 3'b001;
                if (op == J || op == JAL) begin pcw = 1; pcs = 2'b11; end
                if (op == JAL) rw = 1;
                if (op == JR) begin pcw = 1; pcs = 2'b10; end
                if (!is_defined(op) && op != HALT_OP) pcw = 1;
            end
            P_EXE: begin
                st = 3'b010;
                if (op inside {BEQ, BNE, BLTZ}) begin pcw = 1; pcs = taken ? 2'b01 : 2'b00; end
            end
            P_MEM: begin st = 3'b011; mrd = (op == LW); mwr = (op == SW); pcw = (op == SW); end
            P_WB: begin
                st = 3'b100; rw = 1; wds = 1; pcw = 1; dbs = (op == LW);
                rd = rtype ? 2'b10 : (itype ? 2'b01 : 2'b00);
            end
            default: st = 3'b111;
        endcase
        return {st, pcw, irw, imr, rw, rd, wds, asa, asb, ext, aop, mrd, mwr, dbs, pcs};
    endfunction

    // Called inside an IF cycle; returns inside the next instruction's IF cycle (or right after abort).
    task automatic run_instr(input logic [5:0] op, input bit force_zs, input logic z, input logic s,
                             input int abort_at);
        int ph[$];
        int pcw_cnt;
        logic [5:0] cur;
        pcw_cnt = 0;
        ph = '{P_IF, P_ID};
        if (op == HALT_OP) ph.push_back(P_HALT);
        else if (is_defined(op) && !(op inside {J, JR, JAL})) begin
            ph.push_back(P_EXE);
            if (op inside {LW, SW}) ph.push_back(P_MEM);
            if (!(op inside {BEQ, BNE, BLTZ, SW})) ph.push_back(P_WB);
        end
        foreach (ph[k]) begin
            if (k > 0) @(posedge CLK);
            #1;
            cur = (ph[k] == P_IF) ? 6'($urandom_range(0, 63)) : op;
            bus.opcode = cur;
            bus.zero   = force_zs ? z : 1'($urandom_range(0, 1));
            bus.sign   = force_zs ? s : 1'($urandom_range(0, 1));
            #1;
            check_eq($sformatf("op%b_ph%0d", op, ph[k]), 32'(observed()),
                     32'(model(ph[k], cur, bus.zero, bus.sign)));
            pcw_cnt += int'(bus.PCWre);
            if (k == abort_at) begin
                Reset = 1'b0;
                #1;
                check_eq("reset_async", 32'(observed()), 32'd0);
                return;
            end
        end
        if (op != HALT_OP) check_eq($sformatf("pcwre_once_op%b", op), pcw_cnt, 1);
        @(posedge CLK);
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] ops [17];
        ops = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTIU, SW, LW, BEQ, BNE, BLTZ, J, JR, JAL};
        bus.opcode = 6'd0;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;
        repeat (2) @(posedge CLK);
        #2 check_eq("reset_outputs", 32'(observed()), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;

        run_instr(ADD,  0, 0, 0, -1);
        run_instr(LW,   0, 0, 0, -1);
        run_instr(BEQ,  1, 1, 0, -1);
        run_instr(BEQ,  1, 0, 1, -1);
        run_instr(BLTZ, 1, 0, 1, -1);
        run_instr(BNE,  1, 0, 0, -1);
        run_instr(JAL,  0, 0, 0, -1);
        run_instr(6'b101010, 0, 0, 0, -1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (is_defined(op) || op == HALT_OP);
            end else begin
                op = ops[$urandom_range(0, 16)];
            end
            run_instr(op, 0, 0, 0, -1);
        end

        run_instr(ADD, 0, 0, 0, 2);
        repeat (3) begin
            @(posedge CLK);
            #2 check_eq("reset_held", 32'(observed()), 32'd0);
        end
        @(negedge CLK);
        Reset = 1'b1;
        run_instr(SW, 0, 0, 0, -1);

        run_instr(HALT_OP, 0, 0, 0, -1);
        for (int i = 0; i < 12; i++) begin
            bus.opcode = 6'($urandom_range(0, 63));
            bus.zero   = 1'($urandom_range(0, 1));
            bus.sign   = 1'($urandom_range(0, 1));
            #2 check_eq($sformatf("halt_hold%0d", i), 32'(observed()), 32'(model(P_HALT, 6'd0, 1'b0, 1'b0)));
            @(posedge CLK);
        end
        @(negedge CLK);
        Reset = 1'b0;
        #1 check_eq("halt_reset", 32'(observed()), 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        run_instr(ORI, 0, 0, 0, -1);
        run_instr(SLL, 0, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
